// File: rtl/dl_test_sequencer_if.sv
// Handshake/bus bundle between board controller, sequencer and latch DUT.
// master = controller plus DUT side, slave = sequencer.
interface dl_test_sequencer_if;
  logic        start;
  logic [15:0] seed;
  logic        dut_d;
  logic        dut_e;
  logic        dut_q;
  logic        dut_qb;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] err_cnt;
  logic [15:0] vec_cnt;
  logic        mismatch;

  modport master (
    output start, seed, dut_q, dut_qb,
    input  dut_d, dut_e, busy, done, pass,
    input  err_cnt, vec_cnt, mismatch
  );

  modport slave (
    input  start, seed, dut_q, dut_qb,
    output dut_d, dut_e, busy, done, pass,
    output err_cnt, vec_cnt, mismatch
  );
endinterface

// File: rtl/dl_test_sequencer.sv
// Start/done sequenced D-latch tester: LFSR-driven D/E toggles,
// settle window, golden latch model compare, mismatch counting.
module dl_test_sequencer #(
  parameter int NUM_VEC = 1000,
  parameter int GAP_W   = 5,
  parameter int SETTLE  = 2
) (
  input logic               clk,
  input logic               rst_n,
  dl_test_sequencer_if.slave bus
);

  localparam int SET_W = (SETTLE < 2) ? 1 : $clog2(SETTLE);

  typedef enum logic [2:0] {
    ST_IDLE, ST_INIT, ST_APPLY, ST_SETTLE,
    ST_CHECK, ST_GAP, ST_NEXT, ST_DONE
  } state_t;

  state_t           r_state;
  logic [15:0]      r_lfsr;
  logic [15:0]      r_err;
  logic [15:0]      r_vec;
  logic [GAP_W-1:0] r_gap;
  logic [SET_W-1:0] r_set;
  logic             r_d;
  logic             r_e;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic             r_mm;
  logic             r_model;
  logic             r_model_valid;

  logic             w_fb;
  logic             w_d_nxt;
  logic             w_e_nxt;
  logic             w_ok;
  logic [GAP_W-1:0] w_gap;

  assign w_fb    = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
  assign w_d_nxt = r_d ^ r_lfsr[0];
  assign w_e_nxt = r_e ^ r_lfsr[1];
  assign w_gap   = r_lfsr[8 +: GAP_W];
  assign w_ok    = r_model_valid
                 & (bus.dut_q == r_model)
                 & (bus.dut_qb != bus.dut_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_lfsr        <= 16'hACE1;
      r_err         <= '0;
      r_vec         <= '0;
      r_gap         <= '0;
      r_set         <= '0;
      r_d           <= 1'b0;
      r_e           <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_mm          <= 1'b0;
      r_model       <= 1'b0;
      r_model_valid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_mm   <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_lfsr  <= (bus.seed == 16'h0) ? 16'hACE1 : bus.seed;
            r_err   <= '0;
            r_vec   <= '0;
            r_pass  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_INIT;
          end
        end
        ST_INIT: begin
          r_d           <= 1'b0;
          r_e           <= 1'b1;
          r_model       <= 1'b0;
          r_model_valid <= 1'b1;
          r_set         <= '0;
          r_state       <= ST_SETTLE;
        end
        ST_APPLY: begin
          r_d <= w_d_nxt;
          r_e <= w_e_nxt;
          if (w_e_nxt) r_model <= w_d_nxt;
          r_set   <= '0;
          r_state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (r_set == SET_W'(SETTLE - 1)) r_state <= ST_CHECK;
          else r_set <= r_set + 1'b1;
        end
        ST_CHECK: begin
          // X/Z on Q/Qb falls to the else branch and counts as a fail
          if (w_ok) begin
            r_mm <= 1'b0;
          end else begin
            r_mm <= 1'b1;
            if (r_err != 16'hFFFF) r_err <= r_err + 1'b1;
          end
          r_vec   <= r_vec + 1'b1;
          r_gap   <= w_gap;
          r_state <= (w_gap == '0) ? ST_NEXT : ST_GAP;
        end
        ST_GAP: begin
          r_gap <= r_gap - 1'b1;
          if (r_gap == GAP_W'(1)) r_state <= ST_NEXT;
        end
        ST_NEXT: begin
          r_lfsr  <= {w_fb, r_lfsr[15:1]};
          r_state <= (r_vec == 16'(NUM_VEC)) ? ST_DONE : ST_APPLY;
        end
        ST_DONE: begin
          r_done  <= 1'b1;
          r_pass  <= (r_err == 16'h0);
          r_busy  <= 1'b0;
          r_e     <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.dut_d    = r_d;
  assign bus.dut_e    = r_e;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.pass     = r_pass;
  assign bus.err_cnt  = r_err;
  assign bus.vec_cnt  = r_vec;
  assign bus.mismatch = r_mm;

endmodule
